// File: rtl/rx_frame_sequencer_if.sv
// Handshake and data bundle between the SPI slave front end, the frame sequencer and
// the downstream consumer. The sequencer uses the master view; its environment uses slave.
interface rx_frame_sequencer_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TYPE_W  = 2,
    parameter int unsigned MAX_LEN = 16
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic              recieve;
    logic              spi_ready;
    logic [DATA_W-1:0] spi_data;
    logic              spi_begin;
    logic [TYPE_W-1:0] im_type;
    logic              pass_data;
    logic [DATA_W-1:0] data_out;
    logic [LEN_W-1:0]  frame_len;
    logic              frame_done;
    logic [1:0]        frame_err;
    logic              busy;

    modport master (
        input  recieve, spi_ready, spi_data,
        output spi_begin, im_type, pass_data, data_out, frame_len, frame_done, frame_err, busy
    );

    modport slave (
        output recieve, spi_ready, spi_data,
        input  spi_begin, im_type, pass_data, data_out, frame_len, frame_done, frame_err, busy
    );
endinterface

// File: rtl/rx_frame_sequencer.sv
// Frame-level SPI receive sequencer: requests words, captures an optional header type,
// forwards payload and ends the frame on STOP word, length overflow or ready timeout.
module rx_frame_sequencer #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       TYPE_W    = 2,
    parameter logic [DATA_W-1:0] STOP_WORD = 8'hCC,
    parameter int unsigned       MAX_LEN   = 16,
    parameter bit                HDR_EN    = 1'b1,
    parameter int unsigned       TIMEOUT   = 64
) (
    input logic                  clk,
    input logic                  reset,
    rx_frame_sequencer_if.master bus
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StEval, StDone} state_t;

    state_t            state_q;
    logic              spi_ready_q;
    logic [DATA_W-1:0] word_q;
    logic [TMR_W-1:0]  timer_q;
    logic              hdr_q;
    logic              spi_begin_q;
    logic [TYPE_W-1:0] im_type_q;
    logic              pass_data_q;
    logic [DATA_W-1:0] data_out_q;
    logic [LEN_W-1:0]  frame_len_q;
    logic              frame_done_q;
    logic [1:0]        frame_err_q;
    logic              busy_q;
    logic              ready_edge;

    // A level already high when WAIT is entered is not a new word.
    assign ready_edge = bus.spi_ready & ~spi_ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            spi_ready_q  <= 1'b0;
            word_q       <= '0;
            timer_q      <= '0;
            hdr_q        <= 1'b0;
            spi_begin_q  <= 1'b0;
            im_type_q    <= '0;
            pass_data_q  <= 1'b0;
            data_out_q   <= '0;
            frame_len_q  <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            spi_ready_q  <= bus.spi_ready;
            spi_begin_q  <= 1'b0;
            pass_data_q  <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.recieve) begin
                        state_q     <= StReq;
                        frame_len_q <= '0;
                        frame_err_q <= 2'b00;
                        hdr_q       <= HDR_EN;
                        spi_begin_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                StReq: begin
                    timer_q <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (ready_edge) begin
                        word_q  <= bus.spi_data;
                        state_q <= StEval;
                    end else if (TIMEOUT != 0 && timer_q == TMR_LAST) begin
                        state_q      <= StDone;
                        frame_err_q  <= 2'b10;
                        frame_done_q <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                StEval: begin
                    // Header is consumed before any STOP comparison.
                    if (hdr_q) begin
                        im_type_q   <= word_q[TYPE_W-1:0];
                        hdr_q       <= 1'b0;
                        state_q     <= StReq;
                        spi_begin_q <= 1'b1;
                    end else if (word_q == STOP_WORD) begin
                        state_q      <= StDone;
                        frame_err_q  <= 2'b00;
                        frame_done_q <= 1'b1;
                    end else if (frame_len_q == LEN_MAX) begin
                        state_q      <= StDone;
                        frame_err_q  <= 2'b01;
                        frame_done_q <= 1'b1;
                    end else begin
                        pass_data_q <= 1'b1;
                        data_out_q  <= word_q;
                        frame_len_q <= frame_len_q + LEN_W'(1);
                        state_q     <= StReq;
                        spi_begin_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.spi_begin  = spi_begin_q;
    assign bus.im_type    = im_type_q;
    assign bus.pass_data  = pass_data_q;
    assign bus.data_out   = data_out_q;
    assign bus.frame_len  = frame_len_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Bench for rx_frame_sequencer: table of header/payload frames plus hand-written corner
// sequences; payload words are scoreboarded through per-instance expected queues.
module tb_rx_frame_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rx_frame_sequencer_if #(.DATA_W(8), .TYPE_W(2), .MAX_LEN(16)) bus_a ();
    rx_frame_sequencer_if #(.DATA_W(8), .TYPE_W(2), .MAX_LEN(16)) bus_b ();

    rx_frame_sequencer #(
        .DATA_W(8), .TYPE_W(2), .STOP_WORD(8'hCC), .MAX_LEN(16), .HDR_EN(1'b1), .TIMEOUT(64)
    ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

    rx_frame_sequencer #(
        .DATA_W(8), .TYPE_W(2), .STOP_WORD(8'hCC), .MAX_LEN(16), .HDR_EN(1'b0), .TIMEOUT(64)
    ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    typedef struct packed {
        logic [7:0]      hdr;
        logic [3:0]      n;
        logic [2:0][7:0] w;
        logic [1:0]      typ;
        logic [4:0]      len;
    } row_t;

    row_t       rows [5];
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         done_a = 0, done_b = 0, str_a = 0, str_b = 0;
    logic [4:0] len_a, len_b;
    logic [1:0] err_a, err_b;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Scoreboard side: every strobe must match the oldest expected payload word.
    always @(negedge clk) begin
        if (bus_a.pass_data === 1'b1) begin
            str_a++;
            if (exp_a.size() == 0) begin
                n_checks++;
                $display("FAIL strobe_a: got data_out 0x%0h, want no strobe", bus_a.data_out);
            end else check("data_out_a", 32'(bus_a.data_out), 32'(exp_a.pop_front()));
        end
        if (bus_b.pass_data === 1'b1) begin
            str_b++;
            if (exp_b.size() == 0) begin
                n_checks++;
                $display("FAIL strobe_b: got data_out 0x%0h, want no strobe", bus_b.data_out);
            end else check("data_out_b", 32'(bus_b.data_out), 32'(exp_b.pop_front()));
        end
        if (bus_a.frame_done === 1'b1) begin
            done_a++;
            len_a = bus_a.frame_len;
            err_a = bus_a.frame_err;
        end
        if (bus_b.frame_done === 1'b1) begin
            done_b++;
            len_b = bus_b.frame_len;
            err_b = bus_b.frame_err;
        end
    end

    function automatic row_t mk_row(input logic [7:0] hdr, input int n, input logic [7:0] w0,
                                    input logic [7:0] w1, input logic [7:0] w2,
                                    input logic [1:0] typ, input int len);
        row_t r;
        r.hdr = hdr;
        r.n   = 4'(n);
        r.w   = {w2, w1, w0};
        r.typ = typ;
        r.len = 5'(len);
        return r;
    endfunction

    function automatic logic [31:0] outs(input bit sel);
        if (sel) return {11'd0, bus_b.spi_begin, bus_b.im_type, bus_b.pass_data, bus_b.data_out,
                         bus_b.frame_len, bus_b.frame_done, bus_b.frame_err, bus_b.busy};
        return {11'd0, bus_a.spi_begin, bus_a.im_type, bus_a.pass_data, bus_a.data_out,
                bus_a.frame_len, bus_a.frame_done, bus_a.frame_err, bus_a.busy};
    endfunction

    task automatic set_in(input bit sel, input logic rcv, input logic rdy, input logic [7:0] d);
        if (sel) begin
            bus_b.recieve = rcv; bus_b.spi_ready = rdy; bus_b.spi_data = d;
        end else begin
            bus_a.recieve = rcv; bus_a.spi_ready = rdy; bus_a.spi_data = d;
        end
    endtask

    task automatic start_frame(input bit sel);
        @(posedge clk); #1 set_in(sel, 1'b1, 1'b0, 8'h00);
        @(posedge clk); #1 set_in(sel, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_begin(input bit sel, output int at);
        at = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if ((sel ? bus_b.spi_begin : bus_a.spi_begin) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_checks++;
            $display("FAIL spi_begin_wait: got no request in 200 cycles, want spi_begin");
        end
    endtask

    task automatic drive_word(input bit sel, input logic [7:0] d, input int hold);
        @(posedge clk); #1 set_in(sel, 1'b0, 1'b1, d);
        repeat (hold) @(posedge clk);
        #1 set_in(sel, 1'b0, 1'b0, d);
    endtask

    task automatic send(input bit sel, input logic [7:0] d);
        int t;
        wait_begin(sel, t);
        drive_word(sel, d, 1);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic check_end_a(input string tag, input int d0, input logic [4:0] len,
                               input logic [1:0] err);
        check({tag, "_done"}, 32'(done_a - d0), 32'd1);
        check({tag, "_len"}, 32'(len_a), 32'(len));
        check({tag, "_err"}, 32'(err_a), 32'(err));
        check({tag, "_sb_empty"}, 32'(exp_a.size()), 32'd0);
    endtask

    initial begin
        int d0, s0, t_beg, t_done;
        rows[0] = mk_row(8'h33, 1, 8'h33, 8'h00, 8'h00, 2'b11, 1);
        rows[1] = mk_row(8'hC2, 2, 8'hAA, 8'h55, 8'h00, 2'b10, 2);
        rows[2] = mk_row(8'hCC, 1, 8'hCB, 8'h00, 8'h00, 2'b00, 1);
        rows[3] = mk_row(8'h01, 0, 8'h00, 8'h00, 8'h00, 2'b01, 0);
        rows[4] = mk_row(8'hFE, 3, 8'h00, 8'hFF, 8'hCD, 2'b10, 3);

        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        set_in(1'b1, 1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_outs_a", outs(1'b0), 32'd0);
        check("reset_outs_b", outs(1'b1), 32'd0);

        for (int r = 0; r < 5; r++) begin
            d0 = done_a;
            start_frame(1'b0);
            send(1'b0, rows[r].hdr);
            for (int i = 0; i < int'(rows[r].n); i++) begin
                exp_a.push_back(rows[r].w[i]);
                send(1'b0, rows[r].w[i]);
            end
            send(1'b0, 8'hCC);
            settle();
            check_end_a($sformatf("row%0d", r), d0, rows[r].len, 2'b00);
            check($sformatf("row%0d_im_type", r), 32'(bus_a.im_type), 32'(rows[r].typ));
            check($sformatf("row%0d_busy", r), 32'(bus_a.busy), 32'd0);
        end

        // Overflow: 17 payload words, the last is dropped.
        d0 = done_a;
        s0 = str_a;
        start_frame(1'b0);
        send(1'b0, 8'h5A);
        for (int i = 1; i <= 17; i++) begin
            if (i <= 16) exp_a.push_back(8'(i));
            send(1'b0, 8'(i));
        end
        settle();
        check_end_a("overflow", d0, 5'd16, 2'b01);
        check("overflow_strobes", 32'(str_a - s0), 32'd16);
        check("overflow_data_hold", 32'(bus_a.data_out), 32'h10);

        // Timeout: no ready at all after the request.
        start_frame(1'b0);
        wait_begin(1'b0, t_beg);
        t_done = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus_a.frame_done === 1'b1) begin
                t_done = cyc;
                break;
            end
        end
        check("timeout_latency", 32'(t_done - t_beg), 32'd65);
        check("timeout_err", 32'(bus_a.frame_err), 32'b10);
        @(negedge clk);
        check("timeout_busy_low", 32'(bus_a.busy), 32'd0);
        check("timeout_err_held", 32'(bus_a.frame_err), 32'b10);

        // Ready held high across REQ into WAIT: one capture, then a fresh rise is required.
        d0 = done_a;
        s0 = str_a;
        start_frame(1'b0);
        send(1'b0, 8'h01);
        wait_begin(1'b0, t_beg);
        exp_a.push_back(8'h77);
        drive_word(1'b0, 8'h77, 4);
        repeat (6) @(negedge clk);
        check("held_ready_one_strobe", 32'(str_a - s0), 32'd1);
        check("held_ready_still_busy", 32'(bus_a.busy), 32'd1);
        check("held_ready_no_done", 32'(done_a - d0), 32'd0);
        drive_word(1'b0, 8'hCC, 1);
        settle();
        check_end_a("held_ready", d0, 5'd1, 2'b00);
        check("held_ready_im_type", 32'(bus_a.im_type), 32'b01);

        // Reset while payload word 3 is being presented.
        d0 = done_a;
        start_frame(1'b0);
        send(1'b0, 8'h02);
        exp_a.push_back(8'h11);
        send(1'b0, 8'h11);
        exp_a.push_back(8'h22);
        send(1'b0, 8'h22);
        wait_begin(1'b0, t_beg);
        @(posedge clk);
        #1 set_in(1'b0, 1'b0, 1'b1, 8'h33);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 8'h33);
        @(negedge clk);
        check("midreset_outs", outs(1'b0), 32'd0);
        settle();
        check("midreset_no_done", 32'(done_a - d0), 32'd0);
        check("midreset_sb_empty", 32'(exp_a.size()), 32'd0);
        d0 = done_a;
        start_frame(1'b0);
        send(1'b0, 8'h33);
        exp_a.push_back(8'h33);
        send(1'b0, 8'h33);
        send(1'b0, 8'hCC);
        settle();
        check_end_a("after_reset", d0, 5'd1, 2'b00);
        check("after_reset_im_type", 32'(bus_a.im_type), 32'b11);

        // No-header instance: STOP as the very first word.
        d0 = done_b;
        s0 = str_b;
        start_frame(1'b1);
        send(1'b1, 8'hCC);
        settle();
        check("nohdr_stop_done", 32'(done_b - d0), 32'd1);
        check("nohdr_stop_len", 32'(len_b), 32'd0);
        check("nohdr_stop_err", 32'(err_b), 32'd0);
        check("nohdr_stop_no_strobe", 32'(str_b - s0), 32'd0);
        d0 = done_b;
        start_frame(1'b1);
        exp_b.push_back(8'h3C);
        send(1'b1, 8'h3C);
        send(1'b1, 8'hCC);
        settle();
        check("nohdr_done", 32'(done_b - d0), 32'd1);
        check("nohdr_len", 32'(len_b), 32'd1);
        check("nohdr_im_type", 32'(bus_b.im_type), 32'd0);
        check("nohdr_sb_empty", 32'(exp_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test by 500000 time units, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
